// File: rtl/gpr_file_mp.sv
// gpr_file_mp
// Multi-port general-purpose register file for the pipelined CPU.
//
// There are two write ports (dual retire) and NRD combinational read ports.
// Each read port has a write-through bypass, so a read in the same cycle as
// a write returns the new data. A per-register pending scoreboard reports
// which source registers are still waiting for an in-flight producer.
//
// Ports:
//   clk          clock; all state updates happen on the rising edge
//   reset        synchronous, active-low reset
//   rd_addr      NRD read addresses; port k uses [k*ADDR_W +: ADDR_W]
//   rd_data      NRD read data, combinational; port k uses [k*DATA_W +: DATA_W]
//   rd_busy      pending flag for each read address, after the bypass
//   wr0_*/wr1_*  write enable, address and data; wr1 wins on an address clash
//   sb_set_en    marks sb_set_addr pending (an instruction issued with that destination)
//   sb_set_addr  register to mark pending
//
// There is no valid/ready handshake. The block never stalls, and every input
// is sampled on every cycle. The consumer decides what rd_busy means for it.

module gpr_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr0_en,
  input  logic [ADDR_W-1:0]     wr0_addr,
  input  logic [DATA_W-1:0]     wr0_data,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr1_addr,
  input  logic [DATA_W-1:0]     wr1_data,
  input  logic                  sb_set_en,
  input  logic [ADDR_W-1:0]     sb_set_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("gpr_file_mp: NRD must be in 1..4");
  end

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;

  // Effective commit enables. When register 0 is hardwired, any write or set
  // aimed at it is dropped here.
  logic wr0_ok, wr1_ok, sb_ok;
  assign wr0_ok = wr0_en    && !(HAS_ZERO && (wr0_addr    == '0));
  assign wr1_ok = wr1_en    && !(HAS_ZERO && (wr1_addr    == '0));
  assign sb_ok  = sb_set_en && !(HAS_ZERO && (sb_set_addr == '0));

  // Retiring writes clear pending bits first. A set is applied last so that a
  // newly issued producer takes priority over the one that is retiring.
  always_comb begin
    pend_nxt = pend;
    if (wr0_ok) pend_nxt[wr0_addr]    = 1'b0;
    if (wr1_ok) pend_nxt[wr1_addr]    = 1'b0;
    if (sb_ok)  pend_nxt[sb_set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
      // Issued after wr0, so wr1 wins when both ports hit the same address.
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
      pend <= pend_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              hit0, hit1, is_zero;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit0    = wr0_en && (wr0_addr == addr);
    assign hit1    = wr1_en && (wr1_addr == addr);
    assign is_zero = HAS_ZERO && (addr == '0);

    always_comb begin
      data = regs[addr];
      busy = pend[addr];
      if (!reset || is_zero) begin
        data = '0;
        busy = 1'b0;
      end else begin
        if (hit1)      data = wr1_data;
        else if (hit0) data = wr0_data;
        // The value is being bypassed this cycle, so it is no longer busy.
        if (hit0 || hit1) busy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = busy;
  end

endmodule

// File: doc/gpr_file_mp.md
# gpr_file_mp

Parametrised multi-port general-purpose register file with write-through bypass and a per-register pending scoreboard. It is the next-generation GPR block for the pipelined CPU:
- Width, depth and read-port count are configurable.
- Two write ports support a dual-retire writeback stage.
- Writes commit on the rising edge. Same-cycle reads see the write data through an internal bypass, so no negedge write is needed.
- The scoreboard tells the decode stage which source registers still await an in-flight producer.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- rd_addr  input  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  output  NRD*DATA_W  read data, combinational; port k at [k*DATA_W +: DATA_W]
- rd_busy  output  NRD  pending flag of each read address after bypass
- wr0_en, wr1_en  input  1 each  write enables
- wr0_addr, wr1_addr  input  ADDR_W each  write addresses
- wr0_data, wr1_data  input  DATA_W each  write data
- sb_set_en  input  1  mark a register pending (instruction issued with destination)
- sb_set_addr  input  ADDR_W  register to mark pending

## Operation
- Storage: DEPTH × DATA_W array `regs`, plus DEPTH-bit vector `pend`.
- Write commit (rising edge, reset high):
  - wrX_en=1 writes regs[wrX_addr] ← wrX_data.
  - If both ports target the same address, wr1 wins.
  - Writes to address 0 are dropped when ZERO_REG=1.
- Read port k:
  - Address 0 with ZERO_REG=1 → 0.
  - Else if wr1_en and wr1_addr==rd_addr[k] → wr1_data.
  - Else if wr0_en and wr0_addr==rd_addr[k] → wr0_data.
  - Else regs[rd_addr[k]].
- Scoreboard update (rising edge, reset high):
  - Any write with enable clears pend[addr].
  - sb_set_en sets pend[sb_set_addr].
  - Set and clear to the same address in the same cycle → set wins, because the new producer supersedes the retiring one.
  - sb_set to address 0 is ignored when ZERO_REG=1.
- rd_busy[k]:
  - Equals pend[rd_addr[k]], masked to 0 when a write to that address is enabled in the current cycle, because the data is being bypassed.
  - An sb_set in the current cycle does not affect rd_busy until the next cycle.
  - Always 0 for address 0 when ZERO_REG=1.
- Reset (reset=0 at rising edge):
  - All regs ← 0 and all pend ← 0.
  - Writes and sb_set in that cycle are ignored.
  - While reset is low, rd_data and rd_busy are forced to 0.
- Reset mid-operation: pending producers are discarded; the pipeline flush is the upstream owner's responsibility.
- NRD outside 1..4 is unsupported; elaboration fails via a generate-time check.

## Timing
- Read latency: 0 cycles, combinational from rd_addr / wr* inputs.
- Write latency: committed at edge N, visible from regs at N+1 and through the bypass during cycle N.
- Scoreboard: set at edge N → rd_busy=1 from cycle N+1 until a write to that address is presented. rd_busy drops in the cycle the write is presented (bypass); pend clears at the end of that cycle.
- Reset outputs: rd_data=0 and rd_busy=0 for all k.
- No handshake. The block never stalls; the consumer interprets rd_busy.

## Test plan
- Reset then read: hold reset=0 one cycle, release → rd_data ports read 0 for addresses 1, 17, 31 and rd_busy=0.
- Write/bypass: cycle 0: wr0_en=1, addr=5, data=0xDEADBEEF, rd_addr[0]=5 → rd_data[0]=0xDEADBEEF in cycle 0 and in cycle 1 with wr0_en=0.
- Dual-write collision: wr0 (addr 9, 0x11111111) and wr1 (addr 9, 0x22222222) in the same cycle → bypass and next-cycle read both return 0x22222222.
- Zero register: wr1 to addr 0 with 0xFFFFFFFF, plus sb_set to 0 → rd_data=0 and rd_busy=0 for addr 0 forever.
- Scoreboard: sb_set addr 12 at cycle 0 → rd_busy=1 in cycles 1–3. wr0 to 12 at cycle 4 → rd_busy=0 in cycle 4, pend clear from cycle 5. Repeat with sb_set and wr0 to 12 in the same cycle → rd_busy=1 afterwards.
- Reset mid-operation: pend[3]=1 and regs[3]=0x1234, then reset=0 for one edge with wr0 to 3 asserted → after release, regs[3]=0 and rd_busy=0.
